// File: rtl/booth_mul_unit.sv
// booth_mul_unit: three-stage radix-4 Booth multiplier for MUL/MULH/MULHSU/MULHU.
// Stage 1 Booth-encodes into partial products, stage 2 reduces them with carry-save adders, stage 3 resolves them.
module booth_mul_unit #(
   parameter int WIDTH     = 32,
   parameter int TAG_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           op,
   input  logic [WIDTH-1:0]     src_a,
   input  logic [WIDTH-1:0]     src_b,
   input  logic [TAG_WIDTH-1:0] tag_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     result,
   output logic [TAG_WIDTH-1:0] tag_out
);

   localparam int EW  = WIDTH + 2;
   localparam int NPP = EW / 2;
   localparam int PW  = 2 * WIDTH + 4;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;

   function automatic logic signed [PW-1:0] booth_pp(input logic signed [EW-1:0] a,
                                                      input logic [2:0]           trip);
      logic signed [PW-1:0] ax;
      ax = {{(PW-EW){a[EW-1]}}, a};
      case (trip)
         3'b001, 3'b010: booth_pp = ax;
         3'b011:         booth_pp = ax <<< 1;
         3'b100:         booth_pp = -(ax <<< 1);
         3'b101, 3'b110: booth_pp = -ax;
         default:        booth_pp = '0;
      endcase
   endfunction

   function automatic void csa(input  logic signed [PW-1:0] x,
                               input  logic signed [PW-1:0] y,
                               input  logic signed [PW-1:0] z,
                               output logic signed [PW-1:0] s,
                               output logic signed [PW-1:0] c);
      s = x ^ y ^ z;
      c = ((x & y) | (x & z) | (y & z)) << 1;
   endfunction

   logic                   vld_p0, vld_p1, vld_p2;
   logic [1:0]             op_p0, op_p1;
   logic [TAG_WIDTH-1:0]   tag_p0, tag_p1, tag_p2;
   logic signed [PW-1:0]   pp_p0 [NPP];
   logic signed [PW-1:0]   sum_p1, carry_p1;
   logic [WIDTH-1:0]       res_p2;
   logic                   advance;

   // The stall is global: a result waiting on the consumer freezes every stage.
   assign advance  = !(vld_p2 && !out_ready);
   assign in_ready = advance;

   // ---- stage 1: operand extension and Booth partial products -> _p0
   logic signed [EW-1:0]   a_ext, b_ext;
   logic [EW:0]            b_pad;
   logic signed [PW-1:0]   pp_nxt [NPP];

   always_comb begin
      a_ext = (op == OP_MULH || op == OP_MULHSU) ? {{2{src_a[WIDTH-1]}}, src_a} : {2'b00, src_a};
      b_ext = (op == OP_MULH) ? {{2{src_b[WIDTH-1]}}, src_b} : {2'b00, src_b};
      b_pad = {b_ext, 1'b0};
      for (int g = 0; g < NPP; g++) begin
         pp_nxt[g] = booth_pp(a_ext, b_pad[2*g +: 3]) <<< (2*g);
      end
   end

   // ---- stage 2: carry-save reduction -> _p1
   logic signed [PW-1:0]   sum_nxt, carry_nxt, s_t, c_t;

   always_comb begin
      sum_nxt   = '0;
      carry_nxt = '0;
      s_t       = '0;
      c_t       = '0;
      for (int g = 0; g < NPP; g++) begin
         csa(sum_nxt, carry_nxt, pp_p0[g], s_t, c_t);
         sum_nxt   = s_t;
         carry_nxt = c_t;
      end
   end

   // ---- stage 3: carry-propagate add and word select -> _p2
   logic signed [PW-1:0]   prod;
   logic [WIDTH-1:0]       res_nxt;
   logic                   unused_prod_hi;

   assign prod           = sum_p1 + carry_p1;
   assign res_nxt        = (op_p1 == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
   assign unused_prod_hi = ^prod[PW-1:2*WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else if (flush) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else if (advance) begin
         vld_p0 <= in_valid;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
      end
   end

   always_ff @(posedge clk) begin
      if (advance) begin
         for (int g = 0; g < NPP; g++) begin
            pp_p0[g] <= pp_nxt[g];
         end
         op_p0    <= op;
         tag_p0   <= tag_in;
         sum_p1   <= sum_nxt;
         carry_p1 <= carry_nxt;
         op_p1    <= op_p0;
         tag_p1   <= tag_p0;
         res_p2   <= res_nxt;
         tag_p2   <= tag_p1;
      end
   end

   assign out_valid = vld_p2;
   assign result    = vld_p2 ? res_p2 : '0;
   assign tag_out   = vld_p2 ? tag_p2 : '0;

endmodule

// File: tb/tb_booth_mul_unit.sv
// Testbench for booth_mul_unit: directed scenarios plus a random stream, checked through a result scoreboard.
module tb_booth_mul_unit;

   localparam int W  = 32;
   localparam int TW = 5;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;
   localparam logic [1:0] OP_MULHU  = 2'b11;

   logic          clk = 1'b0;
   logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [1:0]    op;
   logic [W-1:0]  src_a, src_b, result, exp_in;
   logic [TW-1:0] tag_in, tag_out;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit lat_chk = 1'b0;

   typedef struct {
      logic [W-1:0]  res;
      logic [TW-1:0] tag;
      int            cyc;
   } sb_t;
   sb_t sb[$];

   logic          prev_stall = 1'b0;
   logic [W-1:0]  prev_res;
   logic [TW-1:0] prev_tag;

   booth_mul_unit #(.WIDTH(W), .TAG_WIDTH(TW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .src_a(src_a), .src_b(src_b), .tag_in(tag_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .tag_out(tag_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [2*W+1:0] xa, xb, p;
      xa = (o == OP_MULH || o == OP_MULHSU) ? {{(W+2){a[W-1]}}, a} : {{(W+2){1'b0}}, a};
      xb = (o == OP_MULH) ? {{(W+2){b[W-1]}}, b} : {{(W+2){1'b0}}, b};
      p  = xa * xb;
      return (o == OP_MUL) ? p[W-1:0] : p[2*W-1:W];
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Scoreboard: push on acceptance, pop and compare on consumption.
   always @(negedge clk) begin
      sb_t e;
      if (!rst_n) begin
         sb.delete();
         prev_stall = 1'b0;
      end else begin
         if (out_valid) begin
            if (prev_stall) begin
               checks++;
               if (result !== prev_res || tag_out !== prev_tag) begin
                  errors++;
                  $display("FAIL stall_hold: result=%h tag=%0d, required result=%h tag=%0d", result, tag_out, prev_res, prev_tag);
               end
            end
            if (out_ready) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL sb_unexpected: result=%h tag=%0d, required no output", result, tag_out);
               end else begin
                  e = sb.pop_front();
                  if (result !== e.res || tag_out !== e.tag) begin
                     errors++;
                     $display("FAIL sb_data: result=%h tag=%0d, required result=%h tag=%0d", result, tag_out, e.res, e.tag);
                  end
                  if (lat_chk) begin
                     checks++;
                     if (cyc - e.cyc != 3) begin
                        errors++;
                        $display("FAIL sb_latency: latency=%0d, required 3", cyc - e.cyc);
                     end
                  end
               end
            end
         end else begin
            checks++;
            if (result !== '0 || tag_out !== '0) begin
               errors++;
               $display("FAIL idle_zero: result=%h tag=%0d, required 0 and 0", result, tag_out);
            end
         end
         if (flush) sb.delete();
         else if (in_valid && in_ready) begin
            e.res = exp_in;
            e.tag = tag_in;
            e.cyc = cyc;
            sb.push_back(e);
         end
         prev_stall = out_valid && !out_ready;
         prev_res   = result;
         prev_tag   = tag_out;
      end
   end

   // Presents one operation (called just after a rising edge) and returns just after it is accepted.
   task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] t, input logic [W-1:0] e);
      int n;
      op = o; src_a = a; src_b = b; tag_in = t; exp_in = e; in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL issue_accept: in_ready=%b after %0d cycles, required 1", in_ready, n);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || out_valid) && n < 40) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = OP_MUL; src_a = '0; src_b = '0; tag_in = '0; exp_in = '0;
      lat_chk = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks += 4;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
      if (result !== '0)      begin errors++; $display("FAIL rst_result: got %h, required 0", result); end
      if (tag_out !== '0)     begin errors++; $display("FAIL rst_tag: got %0d, required 0", tag_out); end
      if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
      rst_n = 1'b1;
      issue(OP_MUL, 32'd5, 32'd6, 5'd9, 32'd30);
      drain();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL rst_release_drain: %0d outstanding, required 0", sb.size()); end
   endtask

   task automatic test_basic();
      int k;
      out_ready = 1'b1; lat_chk = 1'b1;
      issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB);
      k = 1;
      @(negedge clk);
      while (!out_valid && k < 10) begin
         @(negedge clk);
         k++;
      end
      checks += 3;
      if (k != 3) begin errors++; $display("FAIL basic_latency: got %0d cycles, required 3", k); end
      if (result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL basic_result: got %h, required ffffffeb", result); end
      if (tag_out !== 5'd3) begin errors++; $display("FAIL basic_tag: got %0d, required 3", tag_out); end
      drain();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL basic_drain: %0d outstanding, required 0", sb.size()); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1; lat_chk = 1'b1;
      fork
         begin
            issue(OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
            issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
            issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF);
            issue(OP_MULH,   32'h7FFF_FFFF, 32'h8000_0000, 5'd5, 32'hC000_0000);
         end
         begin
            int n = 0;
            int run = 0;
            while (!out_valid && n < 20) begin
               @(negedge clk);
               n++;
            end
            while (out_valid && run < 10) begin
               run++;
               @(negedge clk);
            end
            checks++;
            if (run != 4) begin errors++; $display("FAIL b2b_run: got %0d consecutive results, required 4", run); end
         end
      join
      drain();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain: %0d outstanding, required 0", sb.size()); end
   endtask

   task automatic test_stall();
      out_ready = 1'b1; lat_chk = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               issue(OP_MUL, W'(100 + i), W'(200 + i), TW'(8 + i), W'((100 + i) * (200 + i)));
            end
         end
         begin
            int n = 0;
            do begin
               @(posedge clk); #1;
               n++;
            end while (!out_valid && n < 20);
            out_ready = 1'b0;
            checks++;
            if (result !== 32'd20000) begin errors++; $display("FAIL stall_first: got %h, required %h", result, 32'd20000); end
            repeat (5) begin
               @(negedge clk);
               checks += 3;
               if (out_valid !== 1'b1)  begin errors++; $display("FAIL stall_valid: got %b, required 1", out_valid); end
               if (in_ready !== 1'b0)   begin errors++; $display("FAIL stall_in_ready: got %b, required 0", in_ready); end
               if (result !== 32'd20000) begin errors++; $display("FAIL stall_result: got %h, required %h", result, 32'd20000); end
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL stall_drain: %0d outstanding, required 0", sb.size()); end
   endtask

   task automatic test_flush();
      out_ready = 1'b1; lat_chk = 1'b1;
      issue(OP_MUL,  32'd11, 32'd12, 5'd20, 32'd132);
      issue(OP_MULH, 32'd13, 32'd14, 5'd21, 32'd0);
      issue(OP_MUL,  32'd15, 32'd16, 5'd22, 32'd240);
      flush = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0; out_ready = 1'b1;
      op = OP_MULHU; src_a = 32'hFFFF_FFFF; src_b = 32'd2; tag_in = 5'd17; exp_in = 32'd1; in_valid = 1'b1;
      @(negedge clk);
      checks += 2;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle1: out_valid=%b, required 0", out_valid); end
      if (in_ready !== 1'b1)  begin errors++; $display("FAIL flush_in_ready: got %b, required 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 2; i <= 3; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle%0d: out_valid=%b, required 0", i, out_valid); end
      end
      @(negedge clk);
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_after_valid: got %b, required 1", out_valid); end
      if (result !== 32'd1)   begin errors++; $display("FAIL flush_after_result: got %h, required 1", result); end
      if (tag_out !== 5'd17)  begin errors++; $display("FAIL flush_after_tag: got %0d, required 17", tag_out); end
      drain();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL flush_drain: %0d outstanding, required 0", sb.size()); end
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b0; lat_chk = 1'b0;
      issue(OP_MUL,  32'd3,          32'd5,          5'd6, 32'd15);
      issue(OP_MULH, 32'h7FFF_FFFF,  32'h7FFF_FFFF,  5'd7, 32'h3FFF_FFFF);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b, required 1", out_valid); end
      #2 rst_n = 1'b0;
      #1;
      checks += 4;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b, required 0", out_valid); end
      if (result !== '0)      begin errors++; $display("FAIL midrst_result: got %h, required 0", result); end
      if (tag_out !== '0)     begin errors++; $display("FAIL midrst_tag: got %0d, required 0", tag_out); end
      if (in_ready !== 1'b1)  begin errors++; $display("FAIL midrst_in_ready: got %b, required 1", in_ready); end
      @(posedge clk); #3;
      rst_n = 1'b1; out_ready = 1'b1;
      repeat (6) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale: out_valid=%b result=%h, required 0", out_valid, result); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      lat_chk = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         op        = 2'($urandom_range(0, 3));
         src_a     = pick();
         src_b     = pick();
         tag_in    = TW'($urandom);
         exp_in    = model(op, src_a, src_b);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      drain();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL random_drain: %0d outstanding, required 0", sb.size()); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_stall();
      test_flush();
      test_reset_midflight();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
